// File: rtl/clock_display_mux_pkg.sv
// Shared constants for the clock display multiplexer: FSM encoding, 7-segment
// patterns, digit positions and the BCD-to-segment decoder.
package clock_disp_pkg;

    localparam int unsigned SEC_W   = 6;
    localparam int unsigned MIN_W   = 6;
    localparam int unsigned HOUR_W  = 5;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned NDIG    = 6;
    localparam int unsigned BCD_W   = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    localparam logic [2:0] DIG_SEC_ONES = 3'd0;
    localparam logic [2:0] DIG_SEC_TENS = 3'd1;
    localparam logic [2:0] DIG_MIN_ONES = 3'd2;
    localparam logic [2:0] DIG_MIN_TENS = 3'd3;
    localparam logic [2:0] DIG_HR_ONES  = 3'd4;
    localparam logic [2:0] DIG_HR_TENS  = 3'd5;

    localparam logic [3:0] BCD_DASH = 4'hF;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Per-field range result captured with the snapshot.
    typedef struct packed {
        logic sec_ok;
        logic min_ok;
        logic hr_ok;
    } snap_t;

    function automatic logic [6:0] seg7(input logic [3:0] code);
        case (code)
            4'd0:     seg7 = SEG_0;
            4'd1:     seg7 = SEG_1;
            4'd2:     seg7 = SEG_2;
            4'd3:     seg7 = SEG_3;
            4'd4:     seg7 = SEG_4;
            4'd5:     seg7 = SEG_5;
            4'd6:     seg7 = SEG_6;
            4'd7:     seg7 = SEG_7;
            4'd8:     seg7 = SEG_8;
            4'd9:     seg7 = SEG_9;
            BCD_DASH: seg7 = SEG_DASH;
            default:  seg7 = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/clock_display_mux_if.sv
// Time-in / display-out bundle between the clock counter and the display mux.
interface clock_display_mux_if;
    logic [5:0] sec;
    logic [5:0] mins;
    logic [4:0] hours;
    logic       update;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       busy;

    modport master (output sec, mins, hours, update, input seg, dp, an, busy);
    modport slave  (input sec, mins, hours, update, output seg, dp, an, busy);
endinterface

// File: rtl/clock_display_mux_bin2bcd_seq.sv
// 6-bit sequential double-dabble: loads on start, six shift-add-3 steps, done held until next start.
module bin2bcd_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] bin,
    output logic       done,
    output logic [3:0] tens,
    output logic [3:0] ones
);
    logic [5:0] sh;
    logic [2:0] cnt;
    logic [3:0] tens_adj;
    logic [3:0] ones_adj;

    always_comb begin
        tens_adj = (tens >= 4'd5) ? tens + 4'd3 : tens;
        ones_adj = (ones >= 4'd5) ? ones + 4'd3 : ones;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '0;
            cnt  <= '0;
            tens <= '0;
            ones <= '0;
            done <= 1'b0;
        end else if (start) begin
            sh   <= bin;
            cnt  <= 3'd6;
            tens <= '0;
            ones <= '0;
            done <= 1'b0;
        end else if (cnt != 3'd0) begin
            // Max input 63 keeps tens below 8, so the dropped tens MSB is always 0.
            {tens, ones, sh} <= {tens_adj[2:0], ones_adj, sh, 1'b0};
            cnt  <= cnt - 3'd1;
            done <= (cnt == 3'd1);
        end
    end
endmodule

// File: rtl/clock_display_mux.sv
// Snapshots HH:MM:SS, converts to BCD and scans six 7-segment digits on a shared bus.
module clock_display_mux
    import clock_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV     = 50000,
    parameter bit          SEG_ACTIVE_LOW  = 1'b1,
    parameter bit          BLANK_LEAD_HOUR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    clock_display_mux_if.slave bus
);
    localparam int unsigned RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [1:0]       state;
    logic [1:0]       state_nx;
    logic             start_c;
    logic             load_c;
    logic             busy;
    logic             pending;
    logic [2:0]       conv_cnt;
    snap_t            snap;
    logic [5:0][3:0]  disp;
    logic [RW-1:0]    refresh_cnt;
    logic [2:0]       digit_idx;

    logic [3:0] sec_t, sec_o, min_t, min_o, hr_t, hr_o;
    logic       sec_done, min_done, hr_done;

    bin2bcd_seq u_sec (.clk(clk), .rst(rst), .start(start_c), .bin(bus.sec),
                       .done(sec_done), .tens(sec_t), .ones(sec_o));
    bin2bcd_seq u_min (.clk(clk), .rst(rst), .start(start_c), .bin(bus.mins),
                       .done(min_done), .tens(min_t), .ones(min_o));
    bin2bcd_seq u_hr  (.clk(clk), .rst(rst), .start(start_c), .bin({1'b0, bus.hours}),
                       .done(hr_done), .tens(hr_t), .ones(hr_o));

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state; LOAD restarts directly when an update is waiting.
    always_comb begin
        state_nx = state;
        start_c  = 1'b0;
        load_c   = 1'b0;
        case (state)
            ST_IDLE: if (bus.update) begin
                start_c  = 1'b1;
                state_nx = ST_CONV;
            end
            ST_CONV: if (conv_cnt == 3'd5) state_nx = ST_LOAD;
            ST_LOAD: begin
                load_c = sec_done & min_done & hr_done;
                if (pending || bus.update) begin
                    start_c  = 1'b1;
                    state_nx = ST_CONV;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= 1'b0;
            pending  <= 1'b0;
            conv_cnt <= '0;
            snap     <= '0;
            disp     <= '0;
        end else begin
            busy <= (state_nx != ST_IDLE);
            if (start_c)                               pending <= 1'b0;
            else if (bus.update && state != ST_IDLE)   pending <= 1'b1;
            if (start_c)               conv_cnt <= '0;
            else if (state == ST_CONV) conv_cnt <= conv_cnt + 3'd1;
            if (start_c) begin
                snap.sec_ok <= (bus.sec <= 6'd59);
                snap.min_ok <= (bus.mins <= 6'd59);
                snap.hr_ok  <= (bus.hours <= 5'd23);
            end
            if (load_c) begin
                disp[DIG_SEC_ONES] <= snap.sec_ok ? sec_o : BCD_DASH;
                disp[DIG_SEC_TENS] <= snap.sec_ok ? sec_t : BCD_DASH;
                disp[DIG_MIN_ONES] <= snap.min_ok ? min_o : BCD_DASH;
                disp[DIG_MIN_TENS] <= snap.min_ok ? min_t : BCD_DASH;
                disp[DIG_HR_ONES]  <= snap.hr_ok  ? hr_o  : BCD_DASH;
                disp[DIG_HR_TENS]  <= snap.hr_ok  ? hr_t  : BCD_DASH;
            end
        end
    end

    // Free-running digit scan, independent of the conversion FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= DIG_SEC_ONES;
        end else if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt <= '0;
            digit_idx   <= (digit_idx == DIG_HR_TENS) ? DIG_SEC_ONES : digit_idx + 3'd1;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    logic [3:0] cur_code;
    logic [6:0] seg_l;
    logic       dp_l;
    logic [5:0] an_l;

    always_comb begin
        case (digit_idx)
            DIG_SEC_ONES: cur_code = disp[0];
            DIG_SEC_TENS: cur_code = disp[1];
            DIG_MIN_ONES: cur_code = disp[2];
            DIG_MIN_TENS: cur_code = disp[3];
            DIG_HR_ONES:  cur_code = disp[4];
            DIG_HR_TENS:  cur_code = disp[5];
            default:      cur_code = 4'd0;
        endcase
        seg_l = seg7(cur_code);
        if (BLANK_LEAD_HOUR && digit_idx == DIG_HR_TENS && cur_code == 4'd0)
            seg_l = SEG_BLANK;
        dp_l = (digit_idx == DIG_MIN_ONES) || (digit_idx == DIG_HR_ONES);
        an_l = 6'(1) << digit_idx;
    end

    assign bus.seg  = SEG_ACTIVE_LOW ? ~seg_l : seg_l;
    assign bus.dp   = SEG_ACTIVE_LOW ? ~dp_l  : dp_l;
    assign bus.an   = SEG_ACTIVE_LOW ? ~an_l  : an_l;
    assign bus.busy = busy;
endmodule

// File: tb/tb_clock_display_mux.sv
// Directed bench: two DUTs differing only in leading-hour blanking, driven in lockstep.
module tb_clock_display_mux;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    clock_display_mux_if bus_a ();
    clock_display_mux_if bus_b ();

    clock_display_mux #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEAD_HOUR(1'b1))
        dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    clock_display_mux #(.REFRESH_DIV(4), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEAD_HOUR(1'b0))
        dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] s, input logic [5:0] m, input logic [4:0] h,
                         input logic upd);
        bus_a.sec = s;  bus_a.mins = m;  bus_a.hours = h;  bus_a.update = upd;
        bus_b.sec = s;  bus_b.mins = m;  bus_b.hours = h;  bus_b.update = upd;
    endtask

    // Wait (bounded) until digit d is enabled, then return both DUTs' segments and dp.
    task automatic read_digit(input int d, output logic [6:0] sa, output logic [6:0] sb,
                              output logic dpa);
        logic [5:0] want;
        int n;
        want = 6'(1) << d;
        n = 0;
        while (bus_a.an !== want && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (bus_a.an !== want || bus_b.an !== want) begin
            errors++;
            $display("FAIL scan_wait digit %0d: an_a=%b an_b=%b required %b", d, bus_a.an, bus_b.an, want);
        end
        sa  = bus_a.seg;
        sb  = bus_b.seg;
        dpa = bus_a.dp;
    endtask

    task automatic test_reset();
        logic [5:0] want;
        drive(6'd0, 6'd0, 5'd0, 1'b0);
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (bus_a.an !== 6'b000001 || bus_a.seg !== 7'h3F || bus_a.dp !== 1'b0 || bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: an=%b seg=%h dp=%b busy=%b required an=000001 seg=3f dp=0 busy=0",
                     bus_a.an, bus_a.seg, bus_a.dp, bus_a.busy);
        end
        rst = 1'b0;
        for (int i = 0; i < 28; i++) begin
            want = 6'(1) << ((i / 4) % 6);
            checks++;
            if (bus_a.an !== want) begin
                errors++;
                $display("FAIL reset_walk cycle %0d: an=%b required %b", i, bus_a.an, want);
            end
            tick();
        end
    endtask

    task automatic test_conversion();
        logic [6:0] sa, sb;
        logic dpa;
        logic [6:0] exp_seg [6] = '{7'h6D, 7'h66, 7'h07, 7'h3F, 7'h4F, 7'h06};
        drive(6'd45, 6'd7, 5'd13, 1'b1);
        tick();
        bus_a.update = 1'b0; bus_b.update = 1'b0;
        for (int k = 0; k < 7; k++) begin
            checks++;
            if (bus_a.busy !== 1'b1) begin
                errors++;
                $display("FAIL conv_busy cycle %0d: busy=%b required 1", k, bus_a.busy);
            end
            tick();
        end
        checks++;
        if (bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL conv_busy_drop: busy=%b required 0", bus_a.busy);
        end
        for (int d = 0; d < 6; d++) begin
            read_digit(d, sa, sb, dpa);
            checks++;
            if (sa !== exp_seg[d] || dpa !== (d == 2 || d == 4)) begin
                errors++;
                $display("FAIL conv_digit %0d: seg=%h dp=%b required seg=%h dp=%b",
                         d, sa, dpa, exp_seg[d], (d == 2 || d == 4));
            end
        end
    endtask

    task automatic test_leading_blank();
        logic [6:0] sa, sb;
        logic dpa;
        drive(6'd0, 6'd0, 5'd9, 1'b1);
        tick();
        bus_a.update = 1'b0; bus_b.update = 1'b0;
        repeat (10) tick();
        read_digit(5, sa, sb, dpa);
        checks++;
        if (sa !== 7'h00) begin
            errors++;
            $display("FAIL blank_on: seg=%h required 00", sa);
        end
        checks++;
        if (sb !== 7'h3F) begin
            errors++;
            $display("FAIL blank_off: seg=%h required 3f", sb);
        end
        read_digit(4, sa, sb, dpa);
        checks++;
        if (sa !== 7'h6F) begin
            errors++;
            $display("FAIL blank_hr_ones: seg=%h required 6f", sa);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] sa, sb;
        logic dpa;
        drive(6'd10, 6'd0, 5'd0, 1'b1);
        tick();
        bus_a.update = 1'b0; bus_b.update = 1'b0;
        for (int k = 0; k < 14; k++) begin
            checks++;
            if (bus_a.busy !== 1'b1) begin
                errors++;
                $display("FAIL pend_busy cycle %0d: busy=%b required 1", k, bus_a.busy);
            end
            if (k == 2) drive(6'd11, 6'd0, 5'd0, 1'b1);
            tick();
            if (k == 2) begin
                bus_a.update = 1'b0; bus_b.update = 1'b0;
            end
        end
        checks++;
        if (bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL pend_busy_drop: busy=%b required 0", bus_a.busy);
        end
        for (int d = 0; d < 2; d++) begin
            read_digit(d, sa, sb, dpa);
            checks++;
            if (sa !== 7'h06) begin
                errors++;
                $display("FAIL pend_digit %0d: seg=%h required 06", d, sa);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [6:0] sa, sb;
        logic dpa;
        logic [6:0] exp_seg [6] = '{7'h5B, 7'h06, 7'h40, 7'h40, 7'h6D, 7'h00};
        drive(6'd12, 6'd60, 5'd5, 1'b1);
        tick();
        bus_a.update = 1'b0; bus_b.update = 1'b0;
        repeat (10) tick();
        for (int d = 0; d < 6; d++) begin
            read_digit(d, sa, sb, dpa);
            checks++;
            if (sa !== exp_seg[d]) begin
                errors++;
                $display("FAIL range_digit %0d: seg=%h required %h", d, sa, exp_seg[d]);
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        logic [6:0] sa, sb;
        logic dpa;
        logic [6:0] exp_seg [6] = '{7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h00};
        drive(6'd33, 6'd44, 5'd22, 1'b1);
        tick();
        bus_a.update = 1'b0; bus_b.update = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus_a.busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_busy: busy=%b required 0", bus_a.busy);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (bus_a.busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_busy_stay cycle %0d: busy=%b required 0", k, bus_a.busy);
            end
        end
        for (int d = 0; d < 6; d++) begin
            read_digit(d, sa, sb, dpa);
            checks++;
            if (sa !== exp_seg[d]) begin
                errors++;
                $display("FAIL abort_digit %0d: seg=%h required %h", d, sa, exp_seg[d]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(6'd0, 6'd0, 5'd0, 1'b0);
        test_reset();
        test_conversion();
        test_leading_blank();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_conv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
